// File: rtl/thumb_fetch_unit.sv
// thumb_fetch_unit: Thumb fetch stage, splits memory words into a halfword queue and presents instructions to decode.
// Define FETCH_THUMB32_EN to pair 32-bit (BL-style) encodings; otherwise every halfword is a 16-bit instruction.
module thumb_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4,
    parameter int          ADDR_W   = 10
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_is32
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
`ifdef FETCH_THUMB32_EN
    localparam bit T32 = 1'b1;
`else
    localparam bit T32 = 1'b0;
`endif
    typedef enum logic {RUN, DISCARD} state_t;
    typedef struct packed {
        logic [15:0] hw;
        logic [31:0] pc;
    } entry_t;
    state_t        state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n, pend_pc, pend_pc_n;
    entry_t        q [QDEPTH];
    entry_t        q_n [QDEPTH];
    logic [PW-1:0] rd, wr, rd_n, wr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mem_req_n, push, pop, valid_n, is32_n;
    entry_t        head;
    logic [15:0]   second_hw;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign mem_addr = fetch_pc[ADDR_W+1:2];

    always_comb begin
        push = state == RUN && mem_req && mem_ready && !redirect;
        pop = instr_valid && instr_ready;
        q_n = q;
        rd_n = pop ? (instr_is32 ? inc(inc(rd)) : inc(rd)) : rd;
        wr_n = wr;
        cnt_n = cnt - (pop ? (instr_is32 ? CW'(2) : CW'(1)) : CW'(0));
        if (push && !fetch_pc[1]) begin
            q_n[wr] = {mem_rdata[15:0], fetch_pc};
            q_n[inc(wr)] = {mem_rdata[31:16], fetch_pc + 32'd2};
            wr_n = inc(inc(wr));
            cnt_n = cnt_n + CW'(2);
        end else if (push) begin
            q_n[wr] = {mem_rdata[31:16], fetch_pc};
            wr_n = inc(wr);
            cnt_n = cnt_n + CW'(1);
        end
        if (redirect) begin
            rd_n = '0;
            wr_n = '0;
            cnt_n = '0;
        end
        // presentation registers look at the queue as it will be after this edge
        head = q_n[rd_n];
        second_hw = q_n[inc(rd_n)].hw;
        is32_n = T32 && head.hw[15:13] == 3'b111 && head.hw[12:11] != 2'b00;
        valid_n = cnt_n >= (is32_n ? CW'(2) : CW'(1));
        state_n = state;
        fetch_pc_n = fetch_pc;
        pend_pc_n = pend_pc;
        if (redirect && (!mem_req || mem_ready)) begin
            state_n = RUN;
            fetch_pc_n = redirect_pc & ~32'd1;
        end else if (redirect) begin
            state_n = DISCARD;
            pend_pc_n = redirect_pc & ~32'd1;
        end else if (state == DISCARD && mem_ready) begin
            state_n = RUN;
            fetch_pc_n = pend_pc;
        end else if (push) begin
            fetch_pc_n = fetch_pc + (fetch_pc[1] ? 32'd2 : 32'd4);
        end
        // an outstanding request is never withdrawn; a new one needs room for a full word
        mem_req_n = (mem_req && !mem_ready) || (state_n == RUN && CW'(QDEPTH) - cnt_n >= CW'(2));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            fetch_pc <= RESET_PC;
            pend_pc <= '0;
            rd <= '0;
            wr <= '0;
            cnt <= '0;
            mem_req <= 1'b0;
            instr_valid <= 1'b0;
            instr <= '0;
            instr_pc <= '0;
            instr_is32 <= 1'b0;
        end else begin
            state <= state_n;
            fetch_pc <= fetch_pc_n;
            pend_pc <= pend_pc_n;
            rd <= rd_n;
            wr <= wr_n;
            cnt <= cnt_n;
            mem_req <= mem_req_n;
            instr_valid <= valid_n;
            if (valid_n) begin
                instr <= is32_n ? {head.hw, second_hw} : {16'h0, head.hw};
                instr_pc <= head.pc;
                instr_is32 <= is32_n;
            end
        end
    end

    always_ff @(posedge clock) q <= q_n;
endmodule

// File: tb/tb_thumb_fetch_unit.sv
// tb_thumb_fetch_unit: directed vectors, corner sequences and a random run against an instruction-stream model.
module tb_thumb_fetch_unit;
`ifdef FETCH_THUMB32_EN
    localparam bit T32 = 1'b1;
`else
    localparam bit T32 = 1'b0;
`endif
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_ready = 1'b0;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b0, instr_is32;
    logic [31:0] instr, instr_pc;
    logic [31:0] mem [1024];
    int          total = 0, bad = 0;

    typedef struct {
        logic [31:0] rpc, addr, naddr, i0, p0, i1, p1;
    } vec_t;
    vec_t tv [5];

    thumb_fetch_unit dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_is32(instr_is32)
    );

    always #5 clock = ~clock;
    assign mem_rdata = mem[mem_addr];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        redirect = 1'b0;
        instr_ready = 1'b0;
        mem_ready = 1'b0;
        tick;
        reset = 1'b0;
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] p);
        return p[1] ? mem[p[11:2]][31:16] : mem[p[11:2]][15:0];
    endfunction

    // next instruction of the architectural stream starting at byte address p
    task automatic ref_next(inout logic [31:0] p, output logic [31:0] ei, output logic e32);
        logic [15:0] a;
        a = hw_at(p);
        if (T32 && a[15:11] >= 5'b11101) begin
            ei = {a, hw_at(p + 32'd2)};
            e32 = 1'b1;
            p = p + 32'd4;
        end else begin
            ei = {16'h0, a};
            e32 = 1'b0;
            p = p + 32'd2;
        end
    endtask

    task automatic fill_pattern;
        for (int i = 0; i < 1024; i++)
            mem[i] = {16'h1000 + 16'(2 * i + 1), 16'h1000 + 16'(2 * i)};
    endtask

    logic [31:0] exp_pc, e_instr, prev_instr, prev_pc, prev_addr;
    logic        e32, was_redir, was_stall, was_wait, prev_is32;
    int          idle, hs;

    initial begin
        tv[0] = '{32'h12, 32'd4, 32'd5, 32'h1009, 32'h12, 32'h100A, 32'h14};
        tv[1] = '{32'h13, 32'd4, 32'd5, 32'h1009, 32'h12, 32'h100A, 32'h14};
        tv[2] = '{32'h40, 32'd16, 32'd17, 32'h1020, 32'h40, 32'h1021, 32'h42};
        tv[3] = '{32'h1002, 32'd0, 32'd1, 32'h1001, 32'h1002, 32'h1002, 32'h1004};
        tv[4] = '{32'hFFFF_FFFE, 32'h3FF, 32'd0, 32'h17FF, 32'hFFFF_FFFE, 32'h1000, 32'h0};
        fill_pattern;
        mem[0] = 32'hBBBB_AAAA;
        tick;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_is32", 32'(instr_is32), 0);
        reset = 1'b0;
        mem_ready = 1'b1;
        instr_ready = 1'b1;
        tick;
        chk("t1_req", 32'(mem_req), 1);
        chk("t1_addr", 32'(mem_addr), 0);
        tick;
        chk("t1_valid0", 32'(instr_valid), 1);
        chk("t1_instr0", instr, 32'h0000_AAAA);
        chk("t1_pc0", instr_pc, 0);
        tick;
        chk("t1_instr1", instr, 32'h0000_BBBB);
        chk("t1_pc1", instr_pc, 2);
        mem[0] = 32'hF800_F000;
        do_reset;
        mem_ready = 1'b1;
        instr_ready = 1'b1;
        tick;
        tick;
`ifdef FETCH_THUMB32_EN
        chk("bl_instr", instr, 32'hF000_F800);
        chk("bl_is32", 32'(instr_is32), 1);
        chk("bl_pc", instr_pc, 0);
        tick;
        chk("bl_next_instr", instr, 32'h0000_1002);
        chk("bl_next_pc", instr_pc, 4);
`else
        chk("bl_instr0", instr, 32'h0000_F000);
        chk("bl_is32_0", 32'(instr_is32), 0);
        chk("bl_pc0", instr_pc, 0);
        tick;
        chk("bl_instr1", instr, 32'h0000_F800);
        chk("bl_is32_1", 32'(instr_is32), 0);
        chk("bl_pc1", instr_pc, 2);
`endif
        fill_pattern;
        do_reset;
        mem_ready = 1'b1;
        tick;
        tick;
        chk("bp_valid", 32'(instr_valid), 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_instr", instr, 32'h1000);
            chk("bp_hold_pc", instr_pc, 0);
            if (k > 0) chk("bp_full_no_req", 32'(mem_req), 0);
            tick;
        end
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_valid", 32'(instr_valid), 1);
            chk("bp_drain_instr", instr, 32'h1000 + 32'(k));
            chk("bp_drain_pc", instr_pc, 32'(2 * k));
            instr_ready = 1'b1;
            tick;
        end
        instr_ready = 1'b0;
        for (int v = 0; v < 5; v++) begin
            redirect = 1'b1;
            redirect_pc = tv[v].rpc;
            instr_ready = 1'b0;
            mem_ready = 1'b1;
            tick;
            redirect = 1'b0;
            chk("tv_req", 32'(mem_req), 1);
            chk("tv_addr", 32'(mem_addr), tv[v].addr);
            chk("tv_flush", 32'(instr_valid), 0);
            tick;
            chk("tv_valid", 32'(instr_valid), 1);
            chk("tv_i0", instr, tv[v].i0);
            chk("tv_p0", instr_pc, tv[v].p0);
            chk("tv_naddr", 32'(mem_addr), tv[v].naddr);
            instr_ready = 1'b1;
            tick;
            chk("tv_i1", instr, tv[v].i1);
            chk("tv_p1", instr_pc, tv[v].p1);
            instr_ready = 1'b0;
        end
        do_reset;
        tick;
        chk("dis_req", 32'(mem_req), 1);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick;
        redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("dis_hold_req", 32'(mem_req), 1);
            chk("dis_hold_addr", 32'(mem_addr), 0);
            chk("dis_no_valid", 32'(instr_valid), 0);
            if (k == 1) mem_ready = 1'b1;
            tick;
        end
        chk("dis_new_req", 32'(mem_req), 1);
        chk("dis_new_addr", 32'(mem_addr), 16);
        chk("dis_stale", 32'(instr_valid), 0);
        tick;
        chk("dis_valid", 32'(instr_valid), 1);
        chk("dis_instr", instr, 32'h1020);
        chk("dis_pc", instr_pc, 32'h40);
        do_reset;
        tick;
        chk("mid_req_before", 32'(mem_req), 1);
        reset = 1'b1;
        #1;
        chk("mid_req_drop", 32'(mem_req), 0);
        mem_ready = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        mem_ready = 1'b0;
        tick;
        chk("mid_restart_req", 32'(mem_req), 1);
        chk("mid_restart_addr", 32'(mem_addr), 0);
        chk("mid_no_valid", 32'(instr_valid), 0);
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        do_reset;
        exp_pc = 32'h0;
        was_redir = 1'b0;
        was_stall = 1'b0;
        was_wait = 1'b0;
        idle = 0;
        hs = 0;
        for (int c = 0; c < 4000; c++) begin
            if (was_redir) chk("rnd_flush", 32'(instr_valid), 0);
            if (was_stall) begin
                chk("rnd_stall_valid", 32'(instr_valid), 1);
                chk("rnd_stall_instr", instr, prev_instr);
                chk("rnd_stall_pc", instr_pc, prev_pc);
                chk("rnd_stall_is32", 32'(instr_is32), 32'(prev_is32));
            end
            if (was_wait) begin
                chk("rnd_req_hold", 32'(mem_req), 1);
                chk("rnd_addr_hold", 32'(mem_addr), prev_addr);
            end
            instr_ready = $urandom_range(0, 3) != 0;
            mem_ready = $urandom_range(0, 4) < 3;
            redirect = $urandom_range(0, 29) == 0;
            redirect_pc = $urandom;
            if (instr_valid && instr_ready) begin
                chk("rnd_pc", instr_pc, exp_pc);
                ref_next(exp_pc, e_instr, e32);
                chk("rnd_instr", instr, e_instr);
                chk("rnd_is32", 32'(instr_is32), 32'(e32));
                exp_pc = instr_pc + (e32 ? 32'd4 : 32'd2);
                hs++;
                idle = 0;
            end else begin
                idle++;
            end
            if (redirect) exp_pc = redirect_pc & ~32'd1;
            was_redir = redirect;
            was_stall = instr_valid && !instr_ready && !redirect;
            was_wait = mem_req && !mem_ready;
            prev_instr = instr;
            prev_pc = instr_pc;
            prev_is32 = instr_is32;
            prev_addr = 32'(mem_addr);
            if (idle > 300) begin
                chk("rnd_progress_timeout", 32'(idle), 0);
                break;
            end
            tick;
        end
        redirect = 1'b0;
        chk("rnd_handshakes", 32'(hs >= 300), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/thumb_fetch_unit.md
Name: thumb_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the Thumb decode/execute core.
- Reads 32-bit memory words and splits them into halfwords; bytes [1:0] of the PC select the lower halfword, [3:2] the upper.
- Buffers halfwords in a small queue and pairs 32-bit encodings (BL prefix/suffix).
- Hands decode one instruction per valid/ready handshake and restarts on a branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000: byte PC of the first fetch after reset.
- QDEPTH, 4: halfword queue depth; even, minimum 4.
- ADDR_W, 10: memory word-address width, giving 1024 words.

Ports:
- clock, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- mem_req, output, 1: word read request; held high until accepted.
- mem_addr, output, ADDR_W: word address, equal to fetch_pc[ADDR_W+1:2].
- mem_ready, input, 1: request accepted; mem_rdata is valid in the same cycle.
- mem_rdata, input, 32: read word.
- redirect, input, 1: branch taken; restart fetch at redirect_pc.
- redirect_pc, input, 32: new byte PC; bit 0 ignored.
- instr_valid, output, 1: an instruction is presented to decode.
- instr_ready, input, 1: decode consumes the instruction this cycle.
- instr, output, 32: the instruction. For 16-bit: {16'h0, hw}. For 32-bit: {first_hw, second_hw}.
- instr_pc, output, 32: byte address of the instruction's first halfword.
- instr_is32, output, 1: the instruction is a 32-bit encoding.

Behaviour:
- Reset values (asynchronous): fetch_pc=RESET_PC, queue empty, state RUN, mem_req=0, instr_valid=0, instr=0, instr_pc=0, instr_is32=0.
- Queue: halfword FIFO with QDEPTH entries. Each entry holds {hw[15:0], pc[31:0]}. Read/write pointers wrap modulo QDEPTH; an occupancy counter runs 0..QDEPTH.
- FSM states:
  - RUN: issue a request when free slots >= 2. Asserting mem_req puts the request in flight; stay in RUN.
  - RUN with mem_req high and mem_ready high: push the halfwords and advance fetch_pc.
  - DISCARD: entered on redirect while a request is unaccepted. Keep mem_req and mem_addr stable. When mem_ready arrives, drop the data, then load fetch_pc with the pending redirect PC and return to RUN.
- mem_req and mem_addr are stable from assertion until mem_ready; a request is never withdrawn.
- Response push rules:
  - fetch_pc[1]=0: push low then high halfword (PCs fetch_pc and fetch_pc+2); fetch_pc += 4.
  - fetch_pc[1]=1: push the high halfword only; fetch_pc += 2, realigning to a word boundary.
- fetch_pc wraps modulo 2^32. mem_addr truncates silently.
- Presentation (registered outputs):
  - If queue head hw[15:11] is 11101, 11110 or 11111, it is a 32-bit instruction and needs 2 entries; otherwise 1.
  - instr_valid=1 once the needed entries are present.
  - While instr_valid && !instr_ready, instr, instr_pc and instr_is32 hold stable.
  - On instr_valid && instr_ready, pop 1 or 2 entries. The next instruction may present in the following cycle, for a throughput of 1 per cycle.
- Latency: with mem_ready tied high, from reset release or redirect to the first instr_valid is 2 cycles: request cycle, then push/present register.
- Same-cycle push and pop is allowed; occupancy = old + pushed - popped.
- Redirect has priority over all other events in its cycle:
  - Queue flushed and instr_valid=0 on the next cycle.
  - A pop in the same cycle is honoured: the instruction counts as consumed.
  - A response arriving in the same cycle is dropped.
  - If no request is in flight, or mem_ready=1 in that cycle: fetch_pc=redirect_pc & ~1, state RUN.
  - Otherwise: store redirect_pc and go to DISCARD.
  - A second redirect during DISCARD overwrites the stored PC.
- Reset mid-request: mem_req drops immediately and any late mem_ready is ignored.

Optional Feature:
- Macro FETCH_THUMB32_EN.
- Defined: 32-bit pairing as described above.
- Undefined: every halfword is delivered as a 16-bit instruction. instr_is32 is tied to 0, there are no 2-entry pops, and a BL prefix passes to decode alone.

Test Plan:
- Reset with RESET_PC=0, mem_ready=1, word0=32'hBBBB_AAAA -> instr 32'h0000AAAA at pc 0, then 32'h0000BBBB at pc 2, on consecutive cycles with instr_ready=1.
- Word0=32'hF800_F000 (BL pair) -> one instr=32'hF000F800, instr_is32=1, instr_pc=0.
- With FETCH_THUMB32_EN undefined, same memory -> two instructions, 32'h0000F000 then 32'h0000F800, both instr_is32=0.
- redirect_pc=32'h0000_0012 -> mem_addr=4. Only the high halfword of word 4 is pushed, with instr_pc=0x12. The next request is mem_addr=5.
- instr_ready=0 for 5 cycles with mem_ready=1 -> queue fills to QDEPTH=4, mem_req stays 0, and instr/instr_pc remain stable throughout.
- mem_ready delayed 3 cycles and redirect to 0x40 in cycle 1 -> mem_addr held until mem_ready, data discarded, next request mem_addr=16, no stale instr_valid.
